// File: rtl/opll_pkg.sv
// rtl/opll_pkg.sv - shared constants, types and port decode for the OPLL write scheduler
package opll_pkg;

    localparam int DEF_CLK_DIV   = 24;
    localparam int DEF_ADDR_WAIT = 12;
    localparam int DEF_DATA_WAIT = 84;

    localparam logic [7:0]  IO_PORT_CHIP0  = 8'h7C;
    localparam logic [7:0]  IO_PORT_CHIP1  = 8'h7A;
    localparam logic [15:0] MEM_PORT_CHIP0 = 16'h7FF4;
    localparam logic [15:0] MEM_PORT_CHIP1 = 16'h7FF2;

    localparam int ENTRY_DATA_W = 8;
    localparam int ENTRY_W      = 2 + ENTRY_DATA_W;

    typedef struct packed {
        logic                    chip;
        logic                    a0;
        logic [ENTRY_DATA_W-1:0] data;
    } wentry_t;

    typedef enum logic {
        ST_IDLE,
        ST_STROBE
    } issue_state_t;

    // Address bit 0 is the A0 select, so only bits [15:1] take part in the match.
    // Returns {hit, chip}; chip 0 wins if both windows somehow match.
    function automatic logic [1:0] port_decode(
        input logic        memreq,
        input logic        ioreq,
        input logic [14:0] addr_hi
    );
        logic hit0;
        logic hit1;
        hit0 = (ioreq  && (addr_hi[6:0] == IO_PORT_CHIP0[7:1])) ||
               (memreq && (addr_hi == MEM_PORT_CHIP0[15:1]));
        hit1 = (ioreq  && (addr_hi[6:0] == IO_PORT_CHIP1[7:1])) ||
               (memreq && (addr_hi == MEM_PORT_CHIP1[15:1]));
        return {hit0 | hit1, ~hit0 & hit1};
    endfunction

endpackage

// File: rtl/opll_wfifo.sv
// rtl/opll_wfifo.sv - single-clock in-order write FIFO with registered count
module opll_wfifo #(
    parameter int WIDTH      = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Full/empty come from the registered count only, so a pop never frees a slot
    // for a push in the same cycle.
    assign full     = count[DEPTH_LOG2];
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/opll_write_scheduler.sv
// rtl/opll_write_scheduler.sv - buffers CPU writes and replays them to two OPLLs with YM2413 wait timing
module opll_write_scheduler
    import opll_pkg::*;
#(
    parameter int CLK_DIV         = DEF_CLK_DIV,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int ADDR_WAIT       = DEF_ADDR_WAIT,
    parameter int DATA_WAIT       = DEF_DATA_WAIT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       bus_memreq,
    input  logic                       bus_ioreq,
    input  logic [15:0]                bus_address,
    input  logic                       bus_write,
    input  logic                       bus_valid,
    output logic                       bus_ready,
    input  logic [7:0]                 bus_wdata,
    output logic                       opll_enable_n,
    output logic [1:0]                 opll_cs_n,
    output logic                       opll_wr_n,
    output logic                       opll_a0,
    output logic [7:0]                 opll_d,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       busy
);

    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int WAIT_MAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0]   div;
    logic               tick;
    logic [1:0]         dec;
    logic               accept;
    wentry_t            push_e;
    wentry_t            head;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               issue;
    issue_state_t       state;
    logic               cur_chip;
    logic [WAIT_W-1:0]  wait_cnt [0:1];

    assign tick          = (div == '0);
    assign opll_enable_n = ~(tick & reset_n);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DIV_ONE;
        end
    end

    assign dec       = port_decode(bus_memreq, bus_ioreq, bus_address[15:1]);
    assign accept    = reset_n & bus_valid & bus_write & dec[1] & ~fifo_full;
    assign bus_ready = accept;
    assign push_e    = {dec[0], bus_address[0], bus_wdata};

    opll_wfifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_wfifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (push_e),
        .pop       (issue),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head = fifo_rdata;

    // Issuing on divider==1 puts the strobe edge at divider==2, so the one tick
    // inside the CLK_DIV-long strobe has a full period of setup and one clk of hold.
    assign issue = (state == ST_IDLE) & ~fifo_empty & (wait_cnt[head.chip] == '0) &
                   (div == DIV_ONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cur_chip  <= 1'b0;
            opll_cs_n <= 2'b11;
            opll_wr_n <= 1'b1;
            opll_a0   <= 1'b0;
            opll_d    <= '0;
            for (int i = 0; i < 2; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (tick && (wait_cnt[i] != '0)) begin
                    wait_cnt[i] <= wait_cnt[i] - WAIT_W'(1);
                end
            end
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state     <= ST_STROBE;
                        cur_chip  <= head.chip;
                        opll_cs_n <= head.chip ? 2'b01 : 2'b10;
                        opll_wr_n <= 1'b0;
                        opll_a0   <= head.a0;
                        opll_d    <= head.data;
                    end
                end
                ST_STROBE: begin
                    // Entered at divider==2; divider==1 again marks CLK_DIV cycles held.
                    if (div == DIV_ONE) begin
                        state              <= ST_IDLE;
                        opll_cs_n          <= 2'b11;
                        opll_wr_n          <= 1'b1;
                        wait_cnt[cur_chip] <= opll_a0 ? WAIT_W'(DATA_WAIT) : WAIT_W'(ADDR_WAIT);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = ~fifo_empty | (state == ST_STROBE) |
                  (wait_cnt[0] != '0) | (wait_cnt[1] != '0);

endmodule
